// File: rtl/act_lut_pkg.sv
// act_lut_pkg: shared widths, lane/table types and the lane slicing helper for act_lut_vec.
package act_lut_pkg;

  localparam int unsigned DEF_LANES      = 8;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_NUM_TABLES = 2;
  localparam int unsigned DEF_TBL_W      = (DEF_NUM_TABLES > 1) ? $clog2(DEF_NUM_TABLES) : 1;
  localparam int unsigned LUT_DEPTH      = 2 ** DEF_DATA_W;
  localparam int unsigned VEC_W          = DEF_LANES * DEF_DATA_W;

  typedef logic [DEF_DATA_W-1:0] lane_t;
  typedef logic [DEF_TBL_W-1:0]  tbl_sel_t;
  typedef logic [VEC_W-1:0]      vec_t;

  // Table swap controller states (shadow build only).
  typedef enum logic {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

  // Lane i of a packed vector; lane 0 sits in the LSBs.
  function automatic lane_t lane_slice(input vec_t vec, input int unsigned i);
    return vec[i*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/act_lut_vec_if.sv
// act_lut_vec_if: vector in/out handshakes, table write port and status for act_lut_vec.
interface act_lut_vec_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TBL_W  = 1
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic [TBL_W-1:0]        in_tbl;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    lut_wen;
  logic [TBL_W-1:0]        lut_wtbl;
  logic [DATA_W-1:0]       lut_waddr;
  logic [DATA_W-1:0]       lut_wdata;
  logic                    lut_swap;
  logic                    lut_swap_done;
  logic                    err;

  modport master (
    output in_valid, in_data, in_tbl, out_ready,
    output lut_wen, lut_wtbl, lut_waddr, lut_wdata, lut_swap,
    input  in_ready, out_valid, out_data, lut_swap_done, err
  );

  modport slave (
    input  in_valid, in_data, in_tbl, out_ready,
    input  lut_wen, lut_wtbl, lut_waddr, lut_wdata, lut_swap,
    output in_ready, out_valid, out_data, lut_swap_done, err
  );

endinterface

// File: rtl/act_lut_table.sv
// act_lut_table: one activation table, one synchronous write port, LANES combinational read ports.
// Contents are deliberately not reset; software reloads them after reset.
module act_lut_table #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    wen,
  input  logic [DATA_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [LANES*DATA_W-1:0] raddr,
  output logic [LANES*DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** DATA_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write lands at the clock edge, so a same-cycle read still sees the old entry.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Per-lane lookup, address is the raw lane bits.
  always_comb begin
    rdata = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      rdata[l*DATA_W +: DATA_W] = mem[raddr[l*DATA_W +: DATA_W]];
    end
  end

endmodule

// File: rtl/act_lut_vec.sv
// act_lut_vec: multi-lane, multi-table activation unit between requant and vector writeback.
// S1 registers lane addresses and table select, S2 (output register) holds the lookup result.
// Define ACT_LUT_SHADOW_EN for double-buffered tables with an atomic active/shadow swap.
module act_lut_vec
  import act_lut_pkg::*;
#(
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_TABLES = DEF_NUM_TABLES
) (
  input logic          clk,
  input logic          rst,
  act_lut_vec_if.slave bus
);

  localparam int unsigned TBL_W = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
  localparam int unsigned VEC_W_L = LANES * DATA_W;
`ifdef ACT_LUT_SHADOW_EN
  localparam int unsigned NUM_BANKS = 2;
`else
  localparam int unsigned NUM_BANKS = 1;
`endif
  localparam int unsigned NUM_INST = NUM_TABLES * NUM_BANKS;

  logic               s1_valid;
  logic [VEC_W_L-1:0] s1_addr;
  logic [TBL_W-1:0]   s1_tbl;
  logic               s1_bad;
  logic               out_valid_q;
  logic [VEC_W_L-1:0] out_data_q;
  logic               err_q;

  logic               out_adv;
  logic               s1_adv;
  logic               in_ready_c;
  logic               in_fire;
  logic               in_bad;
  logic               wr_bad;
  logic               swap_block;
  logic               act_sel;
  logic               wr_bank;
  logic [VEC_W_L-1:0] rd_sel;
  logic [VEC_W_L-1:0] rd_data [NUM_INST];

  // Handshake: a stage advances when it is empty or its consumer advances.
  assign out_adv    = ~out_valid_q | bus.out_ready;
  assign s1_adv     = ~s1_valid | out_adv;
  assign in_ready_c = ~rst & s1_adv & ~swap_block;
  assign in_fire    = bus.in_valid & in_ready_c;
  assign in_bad     = 32'(bus.in_tbl) >= NUM_TABLES;
  assign wr_bad     = bus.lut_wen & (32'(bus.lut_wtbl) >= NUM_TABLES);

  // Table storage: one instance per table and bank; out-of-range writes match no instance.
  for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic bank_wen;
      assign bank_wen = bus.lut_wen & (bus.lut_wtbl == TBL_W'(t)) & (wr_bank == 1'(b));
      act_lut_table #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
      ) u_table (
        .clk   (clk),
        .wen   (bank_wen),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .raddr (s1_addr),
        .rdata (rd_data[t*NUM_BANKS+b])
      );
    end
  end

  // Select the active bank of the table chosen by the vector in S1.
  always_comb begin
    rd_sel = '0;
    for (int unsigned t = 0; t < NUM_TABLES; t++) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if ((s1_tbl == TBL_W'(t)) && (1'(b) == act_sel)) begin
          rd_sel = rd_data[t*NUM_BANKS+b];
        end
      end
    end
  end

  // S1: capture lane addresses and table select on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_tbl   <= '0;
      s1_bad   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_addr <= bus.in_data;
        s1_tbl  <= bus.in_tbl;
        s1_bad  <= in_bad;
      end
    end
  end

  // S2: output register, holds while downstream stalls; bad table select forces zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (out_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_data_q <= s1_bad ? '0 : rd_sel;
      end
    end
  end

  // Sticky error: out-of-range write or accepted vector with an out-of-range table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wr_bad | (in_fire & in_bad)) begin
      err_q <= 1'b1;
    end
  end

`ifdef ACT_LUT_SHADOW_EN
  swap_state_e swap_state;
  swap_state_e swap_state_nxt;
  logic        swap_toggle_c;
  logic        swap_done_q;

  // Swap controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_state <= SWAP_IDLE;
    end else begin
      swap_state <= swap_state_nxt;
    end
  end

  // Swap controller: wait for S1 to drain, then flip all tables at once.
  always_comb begin
    swap_state_nxt = swap_state;
    swap_toggle_c  = 1'b0;
    case (swap_state)
      SWAP_IDLE: begin
        if (bus.lut_swap) begin
          swap_state_nxt = SWAP_PEND;
        end
      end
      SWAP_PEND: begin
        if (!s1_valid) begin
          swap_state_nxt = SWAP_IDLE;
          swap_toggle_c  = 1'b1;
        end
      end
      default: swap_state_nxt = SWAP_IDLE;
    endcase
  end

  // Active bank select and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_sel     <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      act_sel     <= act_sel ^ swap_toggle_c;
      swap_done_q <= swap_toggle_c;
    end
  end

  assign swap_block        = (swap_state == SWAP_PEND);
  assign wr_bank           = ~act_sel;
  assign bus.lut_swap_done = swap_done_q;
`else
  logic unused_swap;

  assign act_sel           = 1'b0;
  assign wr_bank           = 1'b0;
  assign swap_block        = 1'b0;
  assign unused_swap       = bus.lut_swap;
  assign bus.lut_swap_done = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_act_lut_vec.sv
// tb_act_lut_vec: randomized scoreboard bench for act_lut_vec (3 tables, 8 lanes x 8 bits).
module tb_act_lut_vec;
  import act_lut_pkg::*;

  localparam int NT = 3;
  localparam int unsigned TW = 2;
  localparam int unsigned LN = DEF_LANES;
  localparam int unsigned DW = DEF_DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  act_lut_vec_if #(.LANES(LN), .DATA_W(DW), .TBL_W(TW)) bus ();

  act_lut_vec #(.LANES(LN), .DATA_W(DW), .NUM_TABLES(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    vec_t data;
    int   acc;
    bit   lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         bp_mode = 1;
  bit         chk_rdy = 1'b0;
  bit         mdl_err = 1'b0;
  bit         err_pend = 1'b0;
  int         mdl_act = 0;
  int         done_cnt = 0;
  int         rdy_low_cnt = 0;
  bit         prev_stall = 1'b0;
  vec_t       prev_data;
  logic [7:0] bank_m [NT][2][256];
  int         t1_in [8] = '{-128, -1, 0, 1, 127, 2, -2, 64};
  int         t1_ex [8] = '{-64, -1, 0, 0, 63, 1, -1, 32};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // Reference: each lane output is the selected table's entry at the lane's raw code.
  function automatic vec_t mdl_eval(input vec_t d, input int t);
    vec_t r = '0;
    if (t >= NT) return '0;
    for (int unsigned l = 0; l < LN; l++) r[l*DW +: DW] = bank_m[t][mdl_act][lane_slice(d, l)];
    return r;
  endfunction

  function automatic void mdl_write(input int t, input logic [7:0] a, input logic [7:0] d);
    if (t >= NT) err_pend = 1'b1;
`ifdef ACT_LUT_SHADOW_EN
    else bank_m[t][1-mdl_act][a] = d;
`else
    else bank_m[t][mdl_act][a] = d;
`endif
  endfunction

  // Model err follows the edge where the offending event is registered.
  always @(posedge clk) begin
    cyc++;
    if (err_pend && !rst) begin
      mdl_err = 1'b1;
      err_pend = 1'b0;
    end
  end

  // Downstream ready pattern: 0 low, 1 high, 2 toggle, 3 random.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: bus.out_ready = 1'b0;
        1: bus.out_ready = 1'b1;
        2: bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pop on every output handshake, check stall stability, err and in_ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("err", 64'(bus.err), 64'(mdl_err));
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (chk_rdy)
        chk("in_ready", 64'(bus.in_ready),
            64'(!(bus.out_valid && !bus.out_ready && sb.size() == 2)));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      if (bus.lut_swap_done) done_cnt++;
      if (!bus.in_ready) rdy_low_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t d, input int t, input vec_t e, input bit lat);
    int g = 0;
    bit ok = 1'b0;
    int acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_tbl   = TW'(t);
    while (g < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        acc = cyc;
        break;
      end
      g++;
    end
    if (ok && t >= NT) err_pend = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (ok) sb.push_back('{data: e, acc: acc, lat: lat});
    else fail_now("in_accept");
  endtask

  task automatic lut_write(input int t, input logic [7:0] a, input logic [7:0] d);
    bus.lut_wen   = 1'b1;
    bus.lut_wtbl  = TW'(t);
    bus.lut_waddr = a;
    bus.lut_wdata = d;
    mdl_write(t, a, d);
    tick();
    bus.lut_wen = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.lut_wen  = 1'b0;
    bus.lut_swap = 1'b0;
    sb.delete();
    mdl_err  = 1'b0;
    err_pend = 1'b0;
    mdl_act  = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_swap_done", 64'(bus.lut_swap_done), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic load_tables();
    logic signed [7:0] s;
    for (int t = 0; t < NT; t++) begin
      for (int a = 0; a < 256; a++) begin
        s = 8'(a);
        if (t == 0) lut_write(t, 8'(a), 8'(a));
        else if (t == 1) lut_write(t, 8'(a), 8'(s >>> 1));
        else lut_write(t, 8'(a), 8'($urandom));
      end
    end
  endtask

  task automatic random_stream(input int n);
    vec_t d;
    int t;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      t = int'($urandom_range(0, NT - 1));
      send(d, t, mdl_eval(d, t), 1'b0);
    end
  endtask

  initial begin
    vec_t d;
    vec_t e;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_tbl = '0;
    bus.lut_wen = 1'b0;
    bus.lut_wtbl = '0;
    bus.lut_waddr = '0;
    bus.lut_wdata = '0;
    bus.lut_swap = 1'b0;
    repeat (3) tick();
    do_reset();
    bp_mode = 1;
    tick();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    load_tables();
`ifdef ACT_LUT_SHADOW_EN
    bus.lut_swap = 1'b1;
    tick();
    bus.lut_swap = 1'b0;
    mdl_act ^= 1;
    repeat (4) tick();
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < 256; a++) lut_write(t, 8'(a), bank_m[t][mdl_act][a]);
`endif

    // Signed codes through the halving table, exact latency.
    for (int l = 0; l < 8; l++) begin
      d[l*8 +: 8] = 8'(t1_in[l]);
      e[l*8 +: 8] = 8'(t1_ex[l]);
    end
    send(d, 1, e, 1'b1);
    drain();

    // Back-to-back stream under alternating backpressure, then random backpressure.
    chk_rdy = 1'b1;
    bp_mode = 2;
    random_stream(16);
    drain();
    bp_mode = 3;
    random_stream(24);
    bp_mode = 1;
    drain();
    chk_rdy = 1'b0;

    // Write colliding with the S1->S2 read of the same entry.
    d = {8{8'h05}};
    send(d, 0, mdl_eval(d, 0), 1'b1);
    bus.lut_wen   = 1'b1;
    bus.lut_wtbl  = 2'd0;
    bus.lut_waddr = 8'h05;
    bus.lut_wdata = 8'h7F;
    mdl_write(0, 8'h05, 8'h7F);
    send(d, 0, mdl_eval(d, 0), 1'b1);
    bus.lut_wen = 1'b0;
    drain();

    // Out-of-range table select on a vector.
    do_reset();
    d = {$urandom, $urandom};
    send(d, NT, 64'd0, 1'b0);
    send(d, 3, 64'd0, 1'b0);
    drain();
    repeat (3) tick();

    // Out-of-range table write is dropped.
    do_reset();
    lut_write(NT, 8'h10, 8'hAA);
    d = {8{8'h10}};
    for (int t = 0; t < NT; t++) send(d, t, mdl_eval(d, t), 1'b0);
    drain();
    repeat (3) tick();

    // Reset with two vectors in flight.
    bp_mode = 0;
    repeat (2) tick();
    send({$urandom, $urandom}, 0, 64'd0, 1'b0);
    send({$urandom, $urandom}, 1, 64'd0, 1'b0);
    do_reset();
    bp_mode = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale_out", 64'(bus.out_valid), 64'd0);
    end
    tick();
    d = {$urandom, $urandom};
    send(d, 2, mdl_eval(d, 2), 1'b1);
    drain();

`ifdef ACT_LUT_SHADOW_EN
    // Swap during streaming; a second request while pending is absorbed.
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < 256; a++) lut_write(t, 8'(a), 8'(a) ^ 8'hA5 ^ 8'(t));
    done_cnt = 0;
    rdy_low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      int t;
      d = {$urandom, $urandom};
      t = int'($urandom_range(0, NT - 1));
      if (i == 5) bus.lut_swap = 1'b1;
      send(d, t, mdl_eval(d, t), 1'b0);
      if (i == 5) begin
        mdl_act ^= 1;
        tick();
        bus.lut_swap = 1'b0;
      end
    end
    drain();
    chk("swap_done_count", 64'(done_cnt), 64'd1);
    chk("swap_in_ready_low", 64'(rdy_low_cnt > 0), 64'd1);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
